// File: rtl/mem_access_stage_if.sv
// Data-memory request/grant/response bus between the memory-access stage and data memory.
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues loads/stores on the dmem bus, stalls upstream while
// a transaction is outstanding and registers the writeback result for the ME/WB boundary.
module mem_access_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      valid_in,
  input  logic [31:0]               pc_in,
  input  logic [6:0]                opcode_in,
  input  logic [2:0]                funct3_in,
  input  logic [4:0]                rd_in,
  input  logic [31:0]               alu_res_in,
  input  logic [31:0]               reg_2_in,
  output logic                      stall_out,
  mem_access_stage_if.master        dmem,
  output logic                      wb_valid,
  output logic [31:0]               wb_pc,
  output logic [4:0]                wb_rd,
  output logic [31:0]               wb_data,
  output logic                      wb_we,
  output logic                      wb_err
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_GNT   = 2'd1;
  localparam logic [1:0] ST_WAIT_RDATA = 2'd2;

  localparam int              CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   lane_be = 4'b0001 << off;
      2'b01:   lane_be = 4'b0011 << off;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] data);
    case (f3[1:0])
      2'b00:   lane_wdata = {4{data[7:0]}};
      2'b01:   lane_wdata = {2{data[15:0]}};
      default: lane_wdata = data;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  load_extract = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_extract = {{16{sh[15]}}, sh[15:0]};
      3'b100:  load_extract = {24'd0, sh[7:0]};
      3'b101:  load_extract = {16'd0, sh[15:0]};
      default: load_extract = sh;
    endcase
  endfunction

  logic [1:0]    state_r, state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic          cnt_clr_s, cnt_inc_s;
  logic          is_load_s, is_store_s, is_branch_s, is_mem_s;
  logic          illegal_s, misalign_s, mem_err_s, timeout_s;
  logic          req_s, stall_s, complete_s;
  logic [31:0]   wb_data_nxt_s;
  logic          wb_we_nxt_s, wb_err_nxt_s;

  assign is_load_s   = (opcode_in == OP_LOAD);
  assign is_store_s  = (opcode_in == OP_STORE);
  assign is_branch_s = (opcode_in == OP_BRANCH);
  assign is_mem_s    = is_load_s | is_store_s;
  assign misalign_s  = ((funct3_in[1:0] == 2'b01) && alu_res_in[0]) ||
                       ((funct3_in[1:0] == 2'b10) && (alu_res_in[1:0] != 2'b00));
  assign mem_err_s   = is_mem_s & (illegal_s | misalign_s);
  assign timeout_s   = (TIMEOUT != 0) && (cnt_r == CNT_LAST);

  // Legal funct3 encodings differ between loads and stores.
  always_comb begin
    illegal_s = 1'b0;
    if (is_load_s) begin
      case (funct3_in)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal_s = 1'b0;
        default:                                illegal_s = 1'b1;
      endcase
    end else if (is_store_s) begin
      case (funct3_in)
        3'b000, 3'b001, 3'b010: illegal_s = 1'b0;
        default:                illegal_s = 1'b1;
      endcase
    end else begin
      illegal_s = 1'b0;
    end
  end

  // Next-state, handshake and writeback-result selection.
  always_comb begin
    state_nxt_s   = state_r;
    req_s         = 1'b0;
    stall_s       = 1'b0;
    cnt_clr_s     = 1'b0;
    cnt_inc_s     = 1'b0;
    complete_s    = 1'b0;
    wb_data_nxt_s = alu_res_in;
    wb_we_nxt_s   = 1'b0;
    wb_err_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!valid_in) begin
          complete_s = 1'b0;
        end else if (!is_mem_s) begin
          complete_s  = 1'b1;
          wb_we_nxt_s = (rd_in != 5'd0) && !is_branch_s;
        end else if (mem_err_s) begin
          complete_s   = 1'b1;
          wb_err_nxt_s = 1'b1;
        end else begin
          req_s = 1'b1;
          if (dmem.dmem_gnt && is_store_s) begin
            complete_s = 1'b1;
          end else if (dmem.dmem_gnt) begin
            stall_s     = 1'b1;
            cnt_clr_s   = 1'b1;
            state_nxt_s = ST_WAIT_RDATA;
          end else begin
            stall_s     = 1'b1;
            cnt_clr_s   = 1'b1;
            state_nxt_s = ST_WAIT_GNT;
          end
        end
      end
      ST_WAIT_GNT: begin
        req_s = 1'b1;
        if (dmem.dmem_gnt && is_store_s) begin
          complete_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (dmem.dmem_gnt) begin
          stall_s     = 1'b1;
          cnt_clr_s   = 1'b1;
          state_nxt_s = ST_WAIT_RDATA;
        end else if (timeout_s) begin
          complete_s   = 1'b1;
          wb_err_nxt_s = 1'b1;
          state_nxt_s  = ST_IDLE;
        end else begin
          stall_s   = 1'b1;
          cnt_inc_s = 1'b1;
        end
      end
      ST_WAIT_RDATA: begin
        if (dmem.dmem_rvalid) begin
          complete_s    = 1'b1;
          wb_data_nxt_s = load_extract(funct3_in, alu_res_in[1:0], dmem.dmem_rdata);
          wb_we_nxt_s   = (rd_in != 5'd0);
          state_nxt_s   = ST_IDLE;
        end else if (timeout_s) begin
          complete_s   = 1'b1;
          wb_err_nxt_s = 1'b1;
          state_nxt_s  = ST_IDLE;
        end else begin
          stall_s   = 1'b1;
          cnt_inc_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Request fields follow the held EX/ME entry; reset kills any request at once.
  assign dmem.dmem_req   = req_s & reset;
  assign dmem.dmem_we    = is_store_s;
  assign dmem.dmem_addr  = {alu_res_in[31:2], 2'b00};
  assign dmem.dmem_be    = lane_be(funct3_in, alu_res_in[1:0]);
  assign dmem.dmem_wdata = lane_wdata(funct3_in, reg_2_in);
  assign stall_out       = stall_s & reset;

  // FSM state and wait-cycle counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (cnt_clr_s) begin
        cnt_r <= '0;
      end else if (cnt_inc_s) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Writeback register; bubbles clear only valid and write-enable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_valid <= 1'b0;
      wb_pc    <= 32'd0;
      wb_rd    <= 5'd0;
      wb_data  <= 32'd0;
      wb_we    <= 1'b0;
      wb_err   <= 1'b0;
    end else if (complete_s) begin
      wb_valid <= 1'b1;
      wb_pc    <= pc_in;
      wb_rd    <= rd_in;
      wb_data  <= wb_data_nxt_s;
      wb_we    <= wb_we_nxt_s;
      wb_err   <= wb_err_nxt_s;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage with TIMEOUT=4.
module tb_mem_access_stage;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] pc_in;
  logic [6:0]  opcode_in;
  logic [2:0]  funct3_in;
  logic [4:0]  rd_in;
  logic [31:0] alu_res_in;
  logic [31:0] reg_2_in;
  logic        stall_out;
  logic        wb_valid, wb_we, wb_err;
  logic [31:0] wb_pc, wb_data;
  logic [4:0]  wb_rd;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .valid_in   (valid_in),
    .pc_in      (pc_in),
    .opcode_in  (opcode_in),
    .funct3_in  (funct3_in),
    .rd_in      (rd_in),
    .alu_res_in (alu_res_in),
    .reg_2_in   (reg_2_in),
    .stall_out  (stall_out),
    .dmem       (bus.master),
    .wb_valid   (wb_valid),
    .wb_pc      (wb_pc),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_we      (wb_we),
    .wb_err     (wb_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] r2,
                       input logic [31:0] pc);
    valid_in   = v;
    opcode_in  = op;
    funct3_in  = f3;
    rd_in      = rd;
    alu_res_in = alu;
    reg_2_in   = r2;
    pc_in      = pc;
  endtask

  task automatic bus_in(input logic gnt, input logic rv, input logic [31:0] rdata);
    bus.dmem_gnt    = gnt;
    bus.dmem_rvalid = rv;
    bus.dmem_rdata  = rdata;
  endtask

  task automatic check_wb(input string tag, input logic v, input logic [31:0] data,
                          input logic we, input logic err);
    check({tag, ".wb_valid"}, 32'(wb_valid), 32'(v));
    check({tag, ".wb_data"},  wb_data, data);
    check({tag, ".wb_we"},    32'(wb_we), 32'(we));
    check({tag, ".wb_err"},   32'(wb_err), 32'(err));
  endtask

  task automatic idle_cycle;
    drive(1'b0, 7'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    bus_in(1'b0, 1'b0, 32'd0);
    tick();
  endtask

  // Load with grant at entry and rvalid the next cycle.
  task automatic quick_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [3:0] be,
                            input logic [31:0] exp);
    drive(1'b1, OP_LOAD, f3, 5'd7, addr, 32'd0, 32'h0000_0200);
    bus_in(1'b1, 1'b0, 32'd0);
    #1;
    check({tag, ".req"},   32'(bus.dmem_req), 32'd1);
    check({tag, ".be"},    32'(bus.dmem_be), 32'(be));
    check({tag, ".addr"},  bus.dmem_addr, {addr[31:2], 2'b00});
    check({tag, ".stall"}, 32'(stall_out), 32'd1);
    tick();
    bus_in(1'b0, 1'b1, rdata);
    #1;
    check({tag, ".rd_req"},   32'(bus.dmem_req), 32'd0);
    check({tag, ".rd_stall"}, 32'(stall_out), 32'd0);
    check({tag, ".bubble"},   32'(wb_valid), 32'd0);
    tick();
    check_wb(tag, 1'b1, exp, 1'b1, 1'b0);
    check({tag, ".wb_rd"}, 32'(wb_rd), 32'd7);
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 7'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    bus_in(1'b0, 1'b0, 32'd0);
    tick();
    tick();
    check_wb("reset", 1'b0, 32'd0, 1'b0, 1'b0);
    check("reset.wb_pc", wb_pc, 32'd0);
    check("reset.wb_rd", 32'(wb_rd), 32'd0);
    check("reset.req", 32'(bus.dmem_req), 32'd0);
    reset = 1'b1;
    tick();

    // ALU op, then an idle cycle that must hold pc/rd/data
    drive(1'b1, OP_ALU, 3'd0, 5'd5, 32'h0000_1234, 32'd0, 32'h0000_0100);
    #1;
    check("alu.req", 32'(bus.dmem_req), 32'd0);
    check("alu.stall", 32'(stall_out), 32'd0);
    tick();
    check_wb("alu", 1'b1, 32'h0000_1234, 1'b1, 1'b0);
    check("alu.wb_pc", wb_pc, 32'h0000_0100);
    check("alu.wb_rd", 32'(wb_rd), 32'd5);
    bus_in(1'b0, 1'b1, 32'hFFFF_FFFF);
    drive(1'b0, OP_ALU, 3'd0, 5'd9, 32'h0000_9999, 32'd0, 32'h0000_0104);
    tick();
    check_wb("idle", 1'b0, 32'h0000_1234, 1'b0, 1'b0);
    check("idle.wb_rd", 32'(wb_rd), 32'd5);
    bus_in(1'b0, 1'b0, 32'd0);
    drive(1'b1, OP_BR, 3'd0, 5'd3, 32'h0000_0044, 32'd0, 32'h0000_0108);
    tick();
    check_wb("branch", 1'b1, 32'h0000_0044, 1'b0, 1'b0);
    drive(1'b1, OP_ALU, 3'd0, 5'd0, 32'h0000_0055, 32'd0, 32'h0000_010C);
    tick();
    check_wb("alu_x0", 1'b1, 32'h0000_0055, 1'b0, 1'b0);

    quick_load("lb",  3'b000, 32'h0000_0103, 32'h80FF_FFFF, 4'b1000, 32'hFFFF_FF80);
    idle_cycle();
    quick_load("lbu", 3'b100, 32'h0000_0103, 32'h80FF_FFFF, 4'b1000, 32'h0000_0080);
    idle_cycle();
    quick_load("lh",  3'b001, 32'h0000_0102, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
    idle_cycle();
    quick_load("lhu", 3'b101, 32'h0000_0100, 32'h1234_9ABC, 4'b0011, 32'h0000_9ABC);
    idle_cycle();
    quick_load("lw",  3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    idle_cycle();

    // SH with grant three cycles late
    drive(1'b1, OP_STORE, 3'b001, 5'd0, 32'h0000_0202, 32'h0000_BEEF, 32'h0000_0300);
    #1;
    check("sh.req", 32'(bus.dmem_req), 32'd1);
    check("sh.we", 32'(bus.dmem_we), 32'd1);
    check("sh.be", 32'(bus.dmem_be), 32'h0000_000C);
    check("sh.wdata", bus.dmem_wdata, 32'hBEEF_BEEF);
    check("sh.addr", bus.dmem_addr, 32'h0000_0200);
    check("sh.stall0", 32'(stall_out), 32'd1);
    for (int i = 1; i < 3; i++) begin
      tick();
      check("sh.stall_wait", 32'(stall_out), 32'd1);
      check("sh.req_hold", 32'(bus.dmem_req), 32'd1);
      check("sh.be_hold", 32'(bus.dmem_be), 32'h0000_000C);
      check("sh.bubble", 32'(wb_valid), 32'd0);
    end
    tick();
    bus_in(1'b1, 1'b0, 32'd0);
    #1;
    check("sh.gnt_stall", 32'(stall_out), 32'd0);
    tick();
    check("sh.wb_valid", 32'(wb_valid), 32'd1);
    check("sh.wb_we", 32'(wb_we), 32'd0);
    check("sh.wb_err", 32'(wb_err), 32'd0);
    check("sh.wb_pc", wb_pc, 32'h0000_0300);

    // SB with immediate grant completes without stalling
    drive(1'b1, OP_STORE, 3'b000, 5'd0, 32'h0000_0301, 32'h1234_5678, 32'h0000_0304);
    #1;
    check("sb.be", 32'(bus.dmem_be), 32'h0000_0002);
    check("sb.wdata", bus.dmem_wdata, 32'h7878_7878);
    check("sb.stall", 32'(stall_out), 32'd0);
    tick();
    check("sb.wb_valid", 32'(wb_valid), 32'd1);
    check("sb.wb_we", 32'(wb_we), 32'd0);
    bus_in(1'b0, 1'b0, 32'd0);

    // Misaligned and illegal accesses
    drive(1'b1, OP_LOAD, 3'b010, 5'd4, 32'h0000_0101, 32'd0, 32'h0000_0400);
    #1;
    check("lw_mis.req", 32'(bus.dmem_req), 32'd0);
    check("lw_mis.stall", 32'(stall_out), 32'd0);
    tick();
    check("lw_mis.wb_valid", 32'(wb_valid), 32'd1);
    check("lw_mis.wb_err", 32'(wb_err), 32'd1);
    check("lw_mis.wb_we", 32'(wb_we), 32'd0);
    drive(1'b1, OP_LOAD, 3'b011, 5'd4, 32'h0000_0100, 32'd0, 32'h0000_0404);
    #1;
    check("ld_ill.req", 32'(bus.dmem_req), 32'd0);
    tick();
    check("ld_ill.wb_err", 32'(wb_err), 32'd1);
    check("ld_ill.wb_we", 32'(wb_we), 32'd0);
    drive(1'b1, OP_STORE, 3'b001, 5'd0, 32'h0000_0103, 32'd0, 32'h0000_0408);
    #1;
    check("sh_mis.req", 32'(bus.dmem_req), 32'd0);
    tick();
    check("sh_mis.wb_err", 32'(wb_err), 32'd1);
    drive(1'b1, OP_STORE, 3'b100, 5'd0, 32'h0000_0100, 32'd0, 32'h0000_040C);
    tick();
    check("st_ill.wb_err", 32'(wb_err), 32'd1);

    // Timeout: grant never arrives
    drive(1'b1, OP_LOAD, 3'b010, 5'd9, 32'h0000_0400, 32'd0, 32'h0000_0500);
    bus_in(1'b0, 1'b0, 32'd0);
    #1;
    check("to.stall_entry", 32'(stall_out), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to.stall_wait", 32'(stall_out), 32'd1);
    end
    tick();
    check("to.stall_abort", 32'(stall_out), 32'd0);
    tick();
    check_wb("to", 1'b1, 32'h0000_0400, 1'b0, 1'b1);
    idle_cycle();

    // Grant in the abort cycle wins over the timeout
    drive(1'b1, OP_LOAD, 3'b010, 5'd9, 32'h0000_0400, 32'd0, 32'h0000_0504);
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("tg.stall_wait", 32'(stall_out), 32'd1);
    end
    tick();
    bus_in(1'b1, 1'b0, 32'd0);
    #1;
    check("tg.stall_gnt", 32'(stall_out), 32'd1);
    tick();
    bus_in(1'b0, 1'b1, 32'hCAFE_F00D);
    #1;
    check("tg.stall_rv", 32'(stall_out), 32'd0);
    tick();
    check_wb("tg", 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0);
    check("tg.wb_pc", wb_pc, 32'h0000_0504);
    idle_cycle();

    // Reset while waiting for read data, then a clean load
    drive(1'b1, OP_LOAD, 3'b010, 5'd11, 32'h0000_0500, 32'd0, 32'h0000_0600);
    bus_in(1'b1, 1'b0, 32'd0);
    tick();
    bus_in(1'b1, 1'b0, 32'd0);
    reset = 1'b0;
    #1;
    check("rst.req", 32'(bus.dmem_req), 32'd0);
    check_wb("rst", 1'b0, 32'd0, 1'b0, 1'b0);
    check("rst.wb_pc", wb_pc, 32'd0);
    check("rst.wb_rd", 32'(wb_rd), 32'd0);
    tick();
    reset = 1'b1;
    #1;
    check("rst.idle_req", 32'(bus.dmem_req), 32'd1);
    check("rst.idle_stall", 32'(stall_out), 32'd1);
    tick();
    bus_in(1'b0, 1'b1, 32'h1122_3344);
    #1;
    check("rst.rv_stall", 32'(stall_out), 32'd0);
    tick();
    check_wb("rst_ld", 1'b1, 32'h1122_3344, 1'b1, 1'b0);
    check("rst_ld.wb_rd", 32'(wb_rd), 32'd11);
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Memory-access stage sitting directly downstream of the EX/ME pipeline register. It consumes the registered execute results (valid, pc, opcode, funct3, rd, ALU result, rs2 data) and performs loads and stores over a req/gnt/rvalid data-memory handshake. It stalls upstream while a transaction is outstanding and produces registered writeback results for the ME/WB boundary. It also handles byte-lane alignment, load sign extension, misalignment and illegal-funct3 detection, and a bus timeout.

Parameters:
TIMEOUT, 255, max cycles waiting in WAIT_GNT or WAIT_RDATA before abort; 0 disables the timeout.

Ports:
clock  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
valid_in  input  1  EX/ME entry valid
pc_in  input  32  instruction PC
opcode_in  input  7  instruction opcode
funct3_in  input  3  width/sign selector
rd_in  input  5  destination register
alu_res_in  input  32  effective address, or ALU result for non-memory ops
reg_2_in  input  32  store data (rs2)
stall_out  output  1  combinational; 1 = upstream must hold its entry
dmem_req  output  1  memory request
dmem_we  output  1  1 = store
dmem_addr  output  32  {alu_res_in[31:2], 2'b00}
dmem_be  output  4  byte enables
dmem_wdata  output  32  lane-replicated store data
dmem_gnt  input  1  request accepted this cycle
dmem_rvalid  input  1  load data valid
dmem_rdata  input  32  load data word
wb_valid  output  1  registered result valid
wb_pc  output  32  registered PC
wb_rd  output  5  registered destination
wb_data  output  32  registered writeback value
wb_we  output  1  registered register-file write enable
wb_err  output  1  registered: misaligned, illegal, or timeout

Behaviour:
- Reset (reset=0, async): state=IDLE; timeout counter=0; wb_valid, wb_pc, wb_rd, wb_data, wb_we, wb_err all 0. A reset during WAIT_GNT or WAIT_RDATA drops the transaction; dmem_req deasserts immediately.
- Decoding: LOAD=7'b0000011, STORE=7'b0100011, BRANCH=7'b1100011.
  - Load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Any other load funct3 is illegal.
  - Store funct3: 000 SB, 001 SH, 010 SW. Any other store funct3 is illegal.
  - Misaligned: half access with addr[0]=1; word access with addr[1:0]!=0.
- Byte enables:
  - Byte: 4'b0001<<addr[1:0]
  - Half: 4'b0011<<addr[1:0]
  - Word: 4'b1111
- Store data: dmem_wdata = byte replicated x4, half replicated x2, or the full word.
- Load data: extract the addressed lane. LB/LH sign-extend; LBU/LHU zero-extend.
- State IDLE:
  - valid_in=0: wb_valid=0 and wb_we=0 at the next edge. wb_pc, wb_rd and wb_data keep their previous values.
  - Valid non-memory op: no request, stall_out=0. Next edge: wb_valid=1, wb_data=alu_res_in, wb_we=(rd_in!=0 && opcode not STORE/BRANCH), wb_err=0.
  - Misaligned or illegal memory op: no request, stall_out=0. Next edge: wb_valid=1, wb_we=0, wb_err=1.
  - Valid legal memory op: dmem_req=1 combinationally in the same cycle.
    - Store with gnt=1: stall_out=0; next edge wb_valid=1, wb_we=0.
    - Load with gnt=1: stall_out=1; go to WAIT_RDATA.
    - gnt=0: stall_out=1; go to WAIT_GNT.
- State WAIT_GNT:
  - dmem_req and all request fields held; inputs are stable because of the stall.
  - On gnt: a store completes exactly as in IDLE; a load goes to WAIT_RDATA.
- State WAIT_RDATA:
  - dmem_req=0. rvalid is accepted no earlier than the cycle after gnt.
  - On rvalid: stall_out=0; next edge wb_valid=1, wb_data=extracted load value, wb_we=(rd!=0), wb_err=0; return to IDLE.
- Bubbles: while stall_out=1 and the op is not completing, each edge writes wb_valid=0 and wb_we=0.
- Load latency: 2 cycles minimum from entry to wb_valid (gnt in the entry cycle, rvalid in the next).
- Timeout: the counter clears on entering WAIT_GNT or WAIT_RDATA and increments each cycle spent there. When it reaches TIMEOUT (TIMEOUT!=0):
  - abort and return to IDLE, stall_out=0;
  - next edge wb_valid=1, wb_we=0, wb_err=1.
  - A gnt or rvalid arriving in that same cycle takes priority over the abort.
- Stray rvalid in IDLE or WAIT_GNT is ignored.

Test Plan:
- ALU op: valid_in=1, opcode 0110011, rd=5, alu_res=0x1234 -> next cycle wb_valid=1, wb_data=0x1234, wb_we=1, no dmem_req.
- LB at 0x103, gnt in the same cycle, rvalid next cycle with rdata=0x80FFFFFF -> dmem_be=1000, wb_data=0xFFFFFF80 two cycles after entry. Repeat as LBU -> 0x00000080.
- SH at 0x202, reg_2=0x0000BEEF, gnt delayed 3 cycles -> dmem_be=1100, dmem_wdata=0xBEEFBEEF; stall_out=1 for 3 cycles; then wb_valid=1, wb_we=0.
- LW at 0x101 -> no request, wb_err=1, wb_we=0. Load with funct3=011 -> wb_err=1.
- TIMEOUT=4, load with gnt never asserted -> stall released after 4 WAIT_GNT cycles, wb_err=1. Repeat with gnt on the 4th cycle -> normal completion.
- Assert reset mid-WAIT_RDATA -> dmem_req=0, all wb_* outputs 0, state IDLE; the next load completes normally.
